// File: rtl/ps2_receptor_if.sv
// PS/2 receiver port bundle: raw PS/2 lines and rx_en in, received byte and status pulses out.
// state_dbg mirrors the receiver FSM state (0 IDLE, 1 RX, 2 CHECK).
interface ps2_receptor_if;
    logic       ps2c;
    logic       ps2d;
    logic       rx_en;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;
    logic [1:0] state_dbg;

    // Handshake: rx_done_tick is a one-cycle strobe with no ready; dout is valid
    // during the strobe and holds until the next good frame or reset.
    modport master (
        output ps2c, ps2d, rx_en,
        input  dout, rx_done_tick, frame_err, state_dbg
    );

    modport slave (
        input  ps2c, ps2d, rx_en,
        output dout, rx_done_tick, frame_err, state_dbg
    );
endinterface

// File: rtl/ps2_receptor.sv
// PS/2 device-to-host frame receiver with clock glitch filter, frame timeout and stop/parity check.
// Optional odd-parity enforcement is compiled in with the PS2_PARITY_CHECK_EN macro.
module ps2_receptor #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic          clk,
    input  logic          rst,
    ps2_receptor_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RX    = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  ps2c_meta_q, ps2c_sync_q;
    logic                  ps2d_meta_q, ps2d_sync_q;
    logic [FILTER_LEN-1:0] filter_q, filter_d;
    logic                  fclk_q, fclk_d;
    logic                  fall;
    logic [3:0]            cnt_q, cnt_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [9:0]            shreg_q, shreg_d;
    logic [7:0]            dout_q, dout_d;
    logic                  done_q, done_d;
    logic                  ferr_q, ferr_d;
    logic [9:0]            frame_w;
    logic                  frame_ok;
    logic                  unused_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            ps2c_meta_q <= 1'b1;
            ps2c_sync_q <= 1'b1;
            ps2d_meta_q <= 1'b1;
            ps2d_sync_q <= 1'b1;
        end else begin
            ps2c_meta_q <= bus.ps2c;
            ps2c_sync_q <= ps2c_meta_q;
            ps2d_meta_q <= bus.ps2d;
            ps2d_sync_q <= ps2d_meta_q;
        end
    end

    // Filtered clock only moves once FILTER_LEN identical samples agree.
    always_comb begin
        filter_d = {ps2c_sync_q, filter_q[FILTER_LEN-1:1]};
        fclk_d   = fclk_q;
        if (&filter_d) begin
            fclk_d = 1'b1;
        end else if (~|filter_d) begin
            fclk_d = 1'b0;
        end
    end

    assign fall = fclk_q & ~fclk_d;

    // Frame as it will look once the bit on ps2d now is shifted in.
    assign frame_w = {ps2d_sync_q, shreg_q[9:1]};

`ifdef PS2_PARITY_CHECK_EN
    assign frame_ok    = frame_w[9] & (^frame_w[8:0]);
    assign unused_bits = shreg_q[0];
`else
    assign frame_ok    = frame_w[9];
    assign unused_bits = shreg_q[0] ^ frame_w[8];
`endif

    // The verdict is taken on the stop-bit fall and registered, so dout and the
    // strobes are presented during the single CHECK cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        shreg_d = shreg_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fall && !ps2d_sync_q && bus.rx_en) begin
                    state_d = RX;
                    cnt_d   = 4'd10;
                    timer_d = '0;
                end
            end
            RX: begin
                if (fall) begin
                    shreg_d = frame_w;
                    cnt_d   = cnt_q - 4'd1;
                    timer_d = '0;
                    if (cnt_q == 4'd1) begin
                        state_d = CHECK;
                        if (frame_ok) begin
                            dout_d = frame_w[7:0];
                            done_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end
                end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d = IDLE;
                    timer_d = '0;
                    ferr_d  = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            CHECK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            filter_q <= '1;
            fclk_q   <= 1'b1;
            cnt_q    <= '0;
            timer_q  <= '0;
            shreg_q  <= '0;
            dout_q   <= 8'h00;
            done_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            filter_q <= filter_d;
            fclk_q   <= fclk_d;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
            shreg_q  <= shreg_d;
            dout_q   <= dout_d;
            done_q   <= done_d;
            ferr_q   <= ferr_d;
        end
    end

    assign bus.dout         = dout_q;
    assign bus.rx_done_tick = done_q;
    assign bus.frame_err    = ferr_q;
    assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_ps2_receptor.sv
// Self-checking bench for ps2_receptor: PS/2 frames are bit-banged on the raw lines and
// every rx_done_tick is matched against a queue of expected bytes.
module tb_ps2_receptor;
    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 5000;
    localparam int HALF        = 20;
    localparam int LAT         = FILTER_LEN + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ps2_receptor_if bus ();

    ps2_receptor #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int tick_cnt = 0;
    int ferr_cnt = 0;
    int tick_at = -1;

    // Scoreboard monitor: every tick consumes one expected byte.
    always @(posedge clk) begin
        logic [7:0] exp_b;
        #1;
        if (bus.rx_done_tick === 1'b1) begin
            tick_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_tick: dout=%02h, no byte expected", bus.dout);
            end else begin
                exp_b = exp_q.pop_front();
                if (bus.dout !== exp_b) begin
                    bad++;
                    $display("FAIL tick_dout: got %02h, want %02h", bus.dout, exp_b);
                end
            end
        end
        if (bus.frame_err === 1'b1) ferr_cnt++;
        if (bus.rx_done_tick === 1'b1 && bus.frame_err === 1'b1) begin
            total++;
            bad++;
            $display("FAIL tick_and_err_together: both 1, want at most one");
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] data, input logic par, input logic stop);
        return {stop, par, data, 1'b0};
    endfunction

    function automatic logic odd_par(input logic [7:0] data);
        return ~(^data);
    endfunction

    // Drives nbits of the frame (bit 0 = start); records the cycle of the tick after the stop fall.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input bit drop_en);
        tick_at = -1;
        for (int b = 0; b < nbits; b++) begin
            bus.ps2d = bits[b];
            cycles(HALF);
            bus.ps2c = 1'b0;
            for (int k = 1; k <= HALF; k++) begin
                @(posedge clk);
                #1;
                if (b == 10 && bus.rx_done_tick === 1'b1 && tick_at < 0) tick_at = k;
            end
            bus.ps2c = 1'b1;
            if (drop_en && b == 0) bus.rx_en = 1'b0;
        end
        bus.ps2d = 1'b1;
        cycles(HALF);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        cycles(1);
        total++; if (bus.dout !== 8'h00) begin bad++; $display("FAIL reset_dout: got %02h, want 00", bus.dout); end
        total++; if (bus.rx_done_tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b, want 0", bus.rx_done_tick); end
        total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b, want 0", bus.frame_err); end
        total++; if (bus.state_dbg !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d, want 0", bus.state_dbg); end
    endtask

    task automatic test_good_frame();
        int t0 = tick_cnt;
        int f0 = ferr_cnt;
        exp_q.push_back(8'h1C);
        send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11, 1'b0);
        total++; if (tick_at != LAT) begin bad++; $display("FAIL good_latency: tick at cycle %0d, want %0d", tick_at, LAT); end
        total++; if (tick_cnt - t0 != 1) begin bad++; $display("FAIL good_tick_count: got %0d, want 1", tick_cnt - t0); end
        total++; if (ferr_cnt != f0) begin bad++; $display("FAIL good_no_err: got %0d, want 0", ferr_cnt - f0); end
        total++; if (bus.dout !== 8'h1C) begin bad++; $display("FAIL good_dout_hold: got %02h, want 1c", bus.dout); end
        total++; if (bus.state_dbg !== 2'd0) begin bad++; $display("FAIL good_idle: got %0d, want 0", bus.state_dbg); end
    endtask

    task automatic test_bad_parity();
        int t0;
        int f0;
        exp_q.push_back(8'h29);
        send_bits(mk_frame(8'h29, odd_par(8'h29), 1'b1), 11, 1'b0);
        t0 = tick_cnt;
        f0 = ferr_cnt;
`ifdef PS2_PARITY_CHECK_EN
        send_bits(mk_frame(8'h1C, 1'b1, 1'b1), 11, 1'b0);
        total++; if (ferr_cnt - f0 != 1) begin bad++; $display("FAIL parity_err: got %0d pulses, want 1", ferr_cnt - f0); end
        total++; if (tick_cnt != t0) begin bad++; $display("FAIL parity_no_tick: got %0d, want 0", tick_cnt - t0); end
        total++; if (bus.dout !== 8'h29) begin bad++; $display("FAIL parity_dout: got %02h, want 29", bus.dout); end
`else
        exp_q.push_back(8'h1C);
        send_bits(mk_frame(8'h1C, 1'b1, 1'b1), 11, 1'b0);
        total++; if (ferr_cnt != f0) begin bad++; $display("FAIL parity_no_err: got %0d, want 0", ferr_cnt - f0); end
        total++; if (tick_cnt - t0 != 1) begin bad++; $display("FAIL parity_tick: got %0d, want 1", tick_cnt - t0); end
        total++; if (bus.dout !== 8'h1C) begin bad++; $display("FAIL parity_dout: got %02h, want 1c", bus.dout); end
`endif
    endtask

    task automatic test_bad_stop();
        logic [7:0] prev = bus.dout;
        int t0 = tick_cnt;
        int f0 = ferr_cnt;
        send_bits(mk_frame(8'hF0, odd_par(8'hF0), 1'b0), 11, 1'b0);
        total++; if (ferr_cnt - f0 != 1) begin bad++; $display("FAIL stop_err: got %0d pulses, want 1", ferr_cnt - f0); end
        total++; if (tick_cnt != t0) begin bad++; $display("FAIL stop_no_tick: got %0d, want 0", tick_cnt - t0); end
        total++; if (bus.dout !== prev) begin bad++; $display("FAIL stop_dout: got %02h, want %02h", bus.dout, prev); end
    endtask

    task automatic test_timeout();
        logic [7:0] prev = bus.dout;
        int t0 = tick_cnt;
        int f0 = ferr_cnt;
        send_bits(mk_frame(8'h5A, odd_par(8'h5A), 1'b1), 5, 1'b0);
        total++; if (bus.state_dbg !== 2'd1) begin bad++; $display("FAIL timeout_in_rx: got %0d, want 1", bus.state_dbg); end
        cycles(TIMEOUT_CYC + 50);
        total++; if (ferr_cnt - f0 != 1) begin bad++; $display("FAIL timeout_err: got %0d pulses, want 1", ferr_cnt - f0); end
        total++; if (bus.state_dbg !== 2'd0) begin bad++; $display("FAIL timeout_idle: got %0d, want 0", bus.state_dbg); end
        total++; if (bus.dout !== prev) begin bad++; $display("FAIL timeout_dout: got %02h, want %02h", bus.dout, prev); end
        exp_q.push_back(8'hF0);
        send_bits(mk_frame(8'hF0, odd_par(8'hF0), 1'b1), 11, 1'b0);
        total++; if (tick_cnt - t0 != 1) begin bad++; $display("FAIL timeout_recover: got %0d ticks, want 1", tick_cnt - t0); end
    endtask

    task automatic test_glitch_gating();
        int t0 = tick_cnt;
        int f0 = ferr_cnt;
        int left_idle = 0;
        bus.rx_en = 1'b1;
        bus.ps2d = 1'b0;
        bus.ps2c = 1'b0;
        cycles(3);
        bus.ps2c = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (bus.state_dbg !== 2'd0) left_idle++;
        end
        bus.ps2d = 1'b1;
        total++; if (left_idle != 0) begin bad++; $display("FAIL glitch_state: %0d cycles out of IDLE, want 0", left_idle); end
        bus.rx_en = 1'b0;
        send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11, 1'b0);
        bus.rx_en = 1'b1;
        total++; if (tick_cnt != t0) begin bad++; $display("FAIL gated_tick: got %0d, want 0", tick_cnt - t0); end
        total++; if (ferr_cnt != f0) begin bad++; $display("FAIL gated_err: got %0d, want 0", ferr_cnt - f0); end
    endtask

    task automatic test_rx_en_drop();
        int t0 = tick_cnt;
        bus.rx_en = 1'b1;
        exp_q.push_back(8'h29);
        send_bits(mk_frame(8'h29, odd_par(8'h29), 1'b1), 11, 1'b1);
        bus.rx_en = 1'b1;
        total++; if (tick_cnt - t0 != 1) begin bad++; $display("FAIL en_drop_tick: got %0d, want 1", tick_cnt - t0); end
    endtask

    task automatic test_reset_midframe();
        int t0 = tick_cnt;
        int f0 = ferr_cnt;
        send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 4, 1'b0);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(30);
        total++; if (bus.dout !== 8'h00) begin bad++; $display("FAIL midrst_dout: got %02h, want 00", bus.dout); end
        total++; if (bus.state_dbg !== 2'd0) begin bad++; $display("FAIL midrst_state: got %0d, want 0", bus.state_dbg); end
        total++; if (tick_cnt != t0 || ferr_cnt != f0) begin
            bad++; $display("FAIL midrst_pulses: got %0d ticks %0d errs, want 0 0", tick_cnt - t0, ferr_cnt - f0);
        end
        exp_q.push_back(8'h29);
        send_bits(mk_frame(8'h29, odd_par(8'h29), 1'b1), 11, 1'b0);
        total++; if (tick_cnt - t0 != 1) begin bad++; $display("FAIL midrst_next_frame: got %0d ticks, want 1", tick_cnt - t0); end
    endtask

    task automatic test_back_to_back();
        int t0 = tick_cnt;
        int f0 = ferr_cnt;
        logic [7:0] b;
        for (int n = 0; n < 4; n++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_bits(mk_frame(b, odd_par(b), 1'b1), 11, 1'b0);
        end
        total++; if (tick_cnt - t0 != 4) begin bad++; $display("FAIL b2b_ticks: got %0d, want 4", tick_cnt - t0); end
        total++; if (ferr_cnt != f0) begin bad++; $display("FAIL b2b_errs: got %0d, want 0", ferr_cnt - f0); end
    endtask

    initial begin
        bus.ps2c  = 1'b1;
        bus.ps2d  = 1'b1;
        bus.rx_en = 1'b1;
        test_reset();
        test_good_frame();
        test_bad_parity();
        test_bad_stop();
        test_timeout();
        test_glitch_gating();
        test_rx_en_drop();
        test_reset_midframe();
        test_back_to_back();
        cycles(5);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL leftover_expected: %0d bytes never received, want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
